div_iter: RTL
=============

Name: div_iter

Overview:
- Iterative 32-bit radix-2 restoring divider. It is the responder side of the EX-stage divide handshake (start/ready/annul).
- EX holds start_i high and stalls the pipeline while ready_o is low. It drops start_i in the cycle ready_o is seen high, then takes result_o for HI/LO writeback.
- Supports signed and unsigned division. Divide-by-zero completes quickly with a zero result.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- signed_div_i  in  1  1 = signed divide, 0 = unsigned
- opdata1_i  in  WIDTH  dividend
- opdata2_i  in  WIDTH  divisor
- start_i  in  1  request; held high by the initiator until ready_o is seen
- annul_i  in  1  abort the divide in progress
- result_o  out  2*WIDTH  {remainder[63:32], quotient[31:0]}
- ready_o  out  1  result_o valid

Behaviour:
- Reset:
  - The clock is clk; reset is rst, synchronous, active-high.
  - On reset: state=IDLE, cnt=0, ready_o=0, result_o=0, all internal registers cleared.
  - Reset asserted mid-operation aborts immediately and returns to these values.
- States: IDLE, BY_ZERO, ON, END. State is encoded in 2 bits.
- IDLE:
  - Exits only when start_i=1 and annul_i=0.
  - If opdata2_i==0: go to BY_ZERO.
  - Otherwise: go to ON with cnt=0.
  - On entry to ON, latch the operand magnitudes:
    - Signed mode: a negative operand is replaced by its two's-complement negation.
    - Unsigned mode: operands are used as-is.
  - Also latch signed_div_i, the dividend sign and the divisor sign.
  - Operand changes after this latch are ignored.
- BY_ZERO:
  - Next cycle go to END with quotient=0 and remainder=0.
- ON:
  - If annul_i=1: go to IDLE. ready_o stays 0 and no result is produced.
  - Otherwise, while cnt<WIDTH, perform one restoring step per cycle:
    - Shift {rem,quo} left by 1.
    - Trial-subtract the divisor magnitude from the upper part.
    - If the difference is non-negative, keep it and set quo[0]=1; else restore and set quo[0]=0.
    - cnt increments by 1.
  - When cnt==WIDTH, apply the sign fix and go to END:
    - Negate the quotient iff signed mode and the dividend and divisor signs differ.
    - Negate the remainder iff signed mode and the dividend is negative.
- END:
  - ready_o=1 and result_o={rem,quo}, both registered.
  - Held for as long as start_i=1.
  - When start_i=0: next cycle state=IDLE, ready_o=0, result_o=0.
  - A new start_i cannot be accepted in the same cycle END exits; the minimum is one IDLE cycle.
- Latency, counting the first cycle start_i is sampled high in IDLE as cycle 0:
  - Normal divide: ready_o high in cycle 34.
  - Divide by zero: ready_o high in cycle 2.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0 (wraps, no trap).
- Arithmetic:
  - The trial subtraction is WIDTH+1 bits wide so the borrow is explicit.
  - All negations are two's complement, modulo 2^WIDTH.
- Simultaneous events:
  - annul_i=1 takes priority over start_i in every state except END.
  - In END, annul_i is ignored; only start_i=0 releases END.
  - rst overrides everything.
- start_i dropping during ON without annul_i does not abort. The result is still presented in END; if start_i is already low there, END exits to IDLE after one cycle.

Test Plan:
- Unsigned 100/7, start held until ready -> ready_o rises in cycle 34; result_o=0x00000002_0000000E. Drop start -> next cycle ready_o=0, result_o=0.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD. Signed 7/-2 -> result_o=0x00000001_FFFFFFFD.
- Divide by zero: 0x12345678/0, unsigned -> ready_o high in cycle 2; result_o=0.
- Signed 0x80000000/0xFFFFFFFF -> result_o=0x00000000_80000000. Unsigned 0xFFFFFFFF/1 -> result_o=0x00000000_FFFFFFFF.
- Annul: start 100/7, assert annul_i in cycle 10 -> state IDLE next cycle, ready_o never rises. Then start 9/4 -> result_o=0x00000001_00000002 in its cycle 34.
- Reset in cycle 20 of a divide -> next cycle ready_o=0, result_o=0, state IDLE. Operands changed mid-ON have no effect on the result.

Source files
------------

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider answering the EX-stage start/ready/annul
// handshake; result_o carries {remainder, quotient}.
module div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BY_ZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_signed;
  logic               r_a_neg;
  logic               r_b_neg;
  logic               r_ready;
  logic [2*WIDTH-1:0] r_result;

  logic               w_op1_neg;
  logic               w_op2_neg;
  logic [WIDTH-1:0]   w_op1_mag;
  logic [WIDTH-1:0]   w_op2_mag;
  logic [WIDTH:0]     w_partial;
  logic [WIDTH:0]     w_diff;
  logic               w_fits;
  logic [WIDTH-1:0]   w_rem_step;
  logic [WIDTH-1:0]   w_quo_step;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_op1_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign w_op2_neg = signed_div_i & opdata2_i[WIDTH-1];
  assign w_op1_mag = w_op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
  assign w_op2_mag = w_op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

  // The shifted partial remainder needs WIDTH+1 bits; the extra top bit of
  // the difference is the borrow that decides quotient bit vs. restore.
  assign w_partial  = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_partial - {1'b0, r_divisor};
  assign w_fits     = ~w_diff[WIDTH];
  assign w_rem_step = w_fits ? w_diff[WIDTH-1:0] : w_partial[WIDTH-1:0];
  assign w_quo_step = {r_quo[WIDTH-2:0], w_fits};

  assign w_quo_fix = (r_signed & (r_a_neg ^ r_b_neg)) ? (~r_quo + 1'b1) : r_quo;
  assign w_rem_fix = (r_signed & r_a_neg) ? (~r_rem + 1'b1) : r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_signed  <= 1'b0;
      r_a_neg   <= 1'b0;
      r_b_neg   <= 1'b0;
      r_ready   <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i && !annul_i) begin
            r_cnt    <= '0;
            r_signed <= signed_div_i;
            r_a_neg  <= w_op1_neg;
            r_b_neg  <= w_op2_neg;
            if (opdata2_i == '0) begin
              r_state <= S_BY_ZERO;
            end else begin
              r_state   <= S_ON;
              r_rem     <= '0;
              r_quo     <= w_op1_mag;
              r_divisor <= w_op2_mag;
            end
          end
        end
        S_BY_ZERO: begin
          if (annul_i) begin
            r_state <= S_IDLE;
          end else begin
            r_state  <= S_END;
            r_ready  <= 1'b1;
            r_result <= '0;
          end
        end
        S_ON: begin
          if (annul_i) begin
            r_state <= S_IDLE;
          end else if (r_cnt != CNT_W'(WIDTH)) begin
            r_rem <= w_rem_step;
            r_quo <= w_quo_step;
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_state  <= S_END;
            r_ready  <= 1'b1;
            r_result <= {w_rem_fix, w_quo_fix};
          end
        end
        S_END: begin
          // annul_i has no effect once the result is presented.
          if (!start_i) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b0;
            r_result <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o  = r_ready;
  assign result_o = r_result;

endmodule
